// File: rtl/addsub_accumulator_if.sv
// Operand stream, start command and result handshake for addsub_accumulator.
// The master side issues start/len and operands and consumes the result.
// The slave side is the accumulator.
interface addsub_accumulator_if #(
    parameter int n     = 4,
    parameter int LEN_W = 4
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [n-1:0]     in_data;
    logic             in_add_n;
    logic             out_valid;
    logic             out_ready;
    logic [n-1:0]     out_acc;
    logic             out_cout;
    logic             out_overflow;
    logic [LEN_W-1:0] out_count;

    modport master (
        output start, len, in_valid, in_data, in_add_n, out_ready,
        input  in_ready, out_valid, out_acc, out_cout, out_overflow, out_count
    );

    modport slave (
        input  start, len, in_valid, in_data, in_add_n, out_ready,
        output in_ready, out_valid, out_acc, out_cout, out_overflow, out_count
    );
endinterface

// File: rtl/addsub_accumulator.sv
// Burst add/subtract accumulator.
// A start command opens a burst of len operands. Each accepted operand is
// added to or subtracted from a running n-bit result. The final result,
// the carry of the last operation, a sticky signed-overflow flag and the
// operand count are then offered on a valid/ready handshake.
module addsub_accumulator #(
    parameter int n     = 4,
    parameter int LEN_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    addsub_accumulator_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;

    logic [n-1:0]     acc_q;
    logic             cout_q;
    logic             ovf_q;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] rem_q;

    logic             xfer;
    logic [n-1:0]     opnd;
    logic [n:0]       sum;
    logic             ovf_now;

    // Handshake strobes decode straight from the state register.
    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == HOLD);
    assign xfer          = (state_q == ACC) && bus.in_valid;

    // The result is presented directly from the registers. The values stay
    // visible after the handshake until the next start clears them.
    assign bus.out_acc      = acc_q;
    assign bus.out_cout     = cout_q;
    assign bus.out_overflow = ovf_q;
    assign bus.out_count    = count_q;

    // Single adder for both operations. Subtract is acc + ~d + 1.
    // Overflow means the operand signs agree and the result sign differs.
    always_comb begin
        opnd    = bus.in_add_n ? ~bus.in_data : bus.in_data;
        sum     = {1'b0, acc_q} + {1'b0, opnd} + {{n{1'b0}}, bus.in_add_n};
        ovf_now = (acc_q[n-1] == opnd[n-1]) && (sum[n-1] != acc_q[n-1]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic. start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = (bus.len == '0) ? HOLD : ACC;
            end
            ACC: begin
                if (xfer && (rem_q == {{(LEN_W-1){1'b0}}, 1'b1})) state_d = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: cleared on start, updated once per operand transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            rem_q   <= '0;
        end else if (state_q == IDLE && bus.start) begin
            acc_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            rem_q   <= bus.len;
        end else if (xfer) begin
            acc_q   <= sum[n-1:0];
            cout_q  <= sum[n];
            ovf_q   <= ovf_q | ovf_now;
            count_q <= count_q + {{(LEN_W-1){1'b0}}, 1'b1};
            rem_q   <= rem_q - {{(LEN_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed and randomized bench for addsub_accumulator. The reference model
// works in plain integer arithmetic: signed range checks for overflow and a
// borrow comparison for carry.
module tb_addsub_accumulator;
    localparam int N  = 4;
    localparam int LW = 4;
    localparam int MOD = 1 << N;
    localparam int SMAX = (1 << (N-1)) - 1;
    localparam int SMIN = -(1 << (N-1));

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    addsub_accumulator_if #(.n(N), .LEN_W(LW)) bus();
    addsub_accumulator #(.n(N), .LEN_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;
    int m_acc, m_cout, m_ovf, m_cnt;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear;
        m_acc = 0; m_cout = 0; m_ovf = 0; m_cnt = 0;
    endtask

    function automatic int to_signed(input int v);
        return (v > SMAX) ? v - MOD : v;
    endfunction

    // Reference for one operation.
    task automatic model_op(input int d, input bit sub);
        int s, r;
        if (!sub) begin
            s = m_acc + d;
            m_cout = (s >= MOD) ? 1 : 0;
            r = to_signed(m_acc) + to_signed(d);
        end else begin
            s = m_acc - d;
            m_cout = (m_acc >= d) ? 1 : 0;
            r = to_signed(m_acc) - to_signed(d);
        end
        if (r > SMAX || r < SMIN) m_ovf = 1;
        m_acc = ((s % MOD) + MOD) % MOD;
        m_cnt++;
    endtask

    task automatic start_burst(input int l, input string tag);
        bus.start = 1'b1;
        bus.len = l[LW-1:0];
        tick;
        bus.start = 1'b0;
        bus.len = LW'($urandom_range(0, 15));
        model_clear();
        if (l == 0) chk({tag, "_len0_hold"}, bus.out_valid, 1);
        else        chk({tag, "_acc_ready"}, bus.in_ready, 1);
    endtask

    // Offer one operand after some gap cycles with in_valid low and junk data.
    task automatic send(input int d, input bit sub, input int gaps, input bit poke_start, input string tag);
        int k;
        bus.in_valid = 1'b0;
        bus.in_data = N'($urandom_range(0, MOD-1));
        bus.in_add_n = 1'($urandom_range(0, 1));
        bus.start = poke_start;
        bus.len = 4'd1;
        repeat (gaps) tick;
        bus.in_data = d[N-1:0];
        bus.in_add_n = sub;
        bus.in_valid = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            tick;
            k++;
        end
        if (k == 20) begin
            chk({tag, "_ready_timeout"}, 0, 1);
        end else begin
            tick;
            model_op(d, sub);
        end
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_acc"}, bus.out_acc, m_acc);
        chk({tag, "_cout"}, bus.out_cout, m_cout);
        chk({tag, "_ovf"}, bus.out_overflow, m_ovf);
        chk({tag, "_count"}, bus.out_count, m_cnt);
    endtask

    // Stall in HOLD with start pulses, then complete the handshake.
    task automatic finish_burst(input int stall, input string tag);
        bus.out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            bus.start = 1'b1;
            bus.len = 4'd2;
            tick;
            check_result({tag, "_stall"});
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        chk({tag, "_idle_valid"}, bus.out_valid, 0);
        chk({tag, "_idle_ready"}, bus.in_ready, 0);
        chk({tag, "_idle_keep_acc"}, bus.out_acc, m_acc);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_acc"}, bus.out_acc, 0);
        chk({tag, "_cout"}, bus.out_cout, 0);
        chk({tag, "_ovf"}, bus.out_overflow, 0);
        chk({tag, "_count"}, bus.out_count, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l;
        bus.start = 0; bus.len = 0; bus.in_valid = 0; bus.in_data = 0;
        bus.in_add_n = 0; bus.out_ready = 0;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        check_zero("reset");
        tick;
        check_zero("idle_no_start");

        // Add burst: 5 + 6 = 11, signed overflow.
        start_burst(2, "add");
        send(5, 0, 0, 0, "add");
        send(6, 0, 0, 0, "add");
        check_result("add");
        chk("add_acc_const", bus.out_acc, 11);
        chk("add_ovf_const", bus.out_overflow, 1);
        finish_burst(0, "add");

        // Mixed burst: +10 then -5.
        start_burst(2, "mix");
        send(10, 0, 0, 0, "mix");
        send(5, 1, 0, 0, "mix");
        check_result("mix");
        chk("mix_acc_const", bus.out_acc, 5);
        chk("mix_cout_const", bus.out_cout, 1);
        finish_burst(0, "mix");

        // The next start clears the sticky overflow flag.
        start_burst(2, "sticky");
        send(3, 0, 0, 0, "sticky");
        send(3, 0, 0, 0, "sticky");
        check_result("sticky");
        chk("sticky_ovf_const", bus.out_overflow, 0);
        finish_burst(0, "sticky");

        // Wrap: +15 then -15.
        start_burst(2, "wrap");
        send(15, 0, 0, 0, "wrap");
        send(15, 1, 0, 0, "wrap");
        check_result("wrap");
        chk("wrap_acc_const", bus.out_acc, 0);
        chk("wrap_cout_const", bus.out_cout, 1);
        finish_burst(0, "wrap");

        // Gaps on alternate cycles, start pulses during ACC and HOLD, HOLD stall.
        start_burst(3, "stress");
        send(1, 0, 1, 1, "stress");
        send(1, 0, 1, 1, "stress");
        send(1, 0, 1, 1, "stress");
        check_result("stress");
        chk("stress_acc_const", bus.out_acc, 3);
        finish_burst(3, "stress");

        // Zero-length burst.
        start_burst(0, "len0");
        check_result("len0");
        finish_burst(1, "len0");

        // Reset mid-burst discards partial result.
        start_burst(3, "midrst");
        send(7, 0, 0, 0, "midrst");
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_zero("midrst");
        start_burst(2, "after_rst");
        send(4, 1, 0, 0, "after_rst");
        send(9, 0, 0, 0, "after_rst");
        check_result("after_rst");
        finish_burst(0, "after_rst");

        // Reset while holding a result.
        start_burst(1, "holdrst");
        send(6, 0, 0, 0, "holdrst");
        check_result("holdrst");
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_zero("holdrst_z");

        // Randomized bursts, issued back-to-back.
        for (int b = 0; b < 30; b++) begin
            l = $urandom_range(0, 7);
            start_burst(l, "rnd");
            for (int i = 0; i < l; i++)
                send($urandom_range(0, MOD-1), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2), 1'($urandom_range(0, 1)), "rnd");
            check_result("rnd");
            finish_burst($urandom_range(0, 3), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
